instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage for each core. It owns the program counter and drives the byte address into the combinational instruction ROM. In the same cycle it captures the returned word into a 2-entry fetch buffer, which it presents to the decode stage through a valid/ready handshake. It also handles control-flow redirects from execute by flushing the buffer and reloading the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; low 2 bits must be 0.
- PC_BITS, 8: number of live byte-address bits. The default gives 64 words, matching the ROM depth. The PC wraps modulo 2^PC_BITS.
- NOP_INSTR, 32'h0000_0013: word driven on if_instr whenever if_valid = 0.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- imem_addr, output, 32: byte address to the instruction ROM; equals the current PC.
- imem_rdata, input, 32: combinational ROM read data for imem_addr.
- redirect_valid, input, 1: execute requests a PC change this cycle.
- redirect_pc, input, 32: redirect target, byte address.
- if_valid, output, 1: buffer head holds a valid instruction.
- if_ready, input, 1: decode accepts the head this cycle.
- if_instr, output, 32: head instruction, or NOP_INSTR when if_valid = 0.
- if_pc, output, 32: byte address of the head instruction, or 0 when if_valid = 0.
- fetch_count, output, 16: number of words pushed since reset; wraps at 2^16.

## Operation
- State:
  - pc register (PC_BITS live bits, upper bits 0).
  - 2-entry circular buffer of {pc, instr}, with 1-bit read pointer, 1-bit write pointer and 2-bit count (0..2).
  - fetch_count.
- pop = if_valid & if_ready.
- fetch_en = ~redirect_valid & ((count < 2) | pop).
- Fetch cycle (fetch_en = 1):
  - Push {pc, imem_rdata} at the write pointer.
  - pc <= (pc + 4) mod 2^PC_BITS.
  - fetch_count++.
- No fetch (fetch_en = 0, no redirect): pc holds and nothing is pushed.
- Pop: read pointer advances and count decrements. A simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid = 1): takes priority over everything else.
  - count <= 0 and both pointers <= 0.
  - Any pop in that cycle is still honoured by decode, but the buffer is then discarded.
  - pc <= {redirect_pc[PC_BITS-1:2], 2'b00}. Upper bits and misaligned low bits are dropped.
  - No push that cycle.
- Buffer states:
  - EMPTY (count 0): if_valid = 0.
  - ONE (count 1): if_valid = 1.
  - FULL (count 2): if_valid = 1; fetch occurs only if pop.
- Transitions:
  - EMPTY→ONE on fetch.
  - ONE→FULL on fetch without pop.
  - ONE→ONE on fetch with pop.
  - ONE→EMPTY on pop without fetch.
  - FULL→ONE on pop without fetch.
  - FULL→FULL on pop with fetch.
  - Any state→EMPTY on redirect.
- Outputs are driven from the buffer head only. No ROM data is bypassed to decode.

## Timing
- Reset values (reset_n sampled low at a rising edge):
  - pc = RESET_PC and imem_addr = RESET_PC.
  - count = 0, so if_valid = 0, if_instr = NOP_INSTR and if_pc = 0.
  - fetch_count = 0.
- Reset asserted mid-operation discards buffered words and any redirect presented in the same cycle.
- First cycle after reset release:
  - Word at RESET_PC is pushed at the end of that cycle.
  - if_valid = 1 from the next cycle.
- ROM-to-decode latency is 1 cycle. Sustained throughput is 1 instruction per cycle while if_ready = 1.
- Redirect in cycle N:
  - imem_addr = target in cycle N+1.
  - Target word is pushed at the end of N+1.
  - if_valid = 1 with if_pc = target in cycle N+2.
  - if_valid = 0 in cycle N+1 (redirect bubble of 1 cycle).
- Held-off decode:
  - With if_ready = 0, if_valid, if_instr and if_pc hold stable.
  - The buffer fills to 2 and the PC stalls 2 words ahead of the head.
- PC wrap: after pc = 2^PC_BITS - 4 the next PC is 0, with no gap.

## Test plan
- Reset, then if_ready = 1 constantly, with ROM word k = 32'hA000_0000 + k:
  - if_valid rises 1 cycle after release.
  - if_pc sequence is 0, 4, 8, …, with if_instr matching the ROM word at each address.
  - fetch_count increments every cycle.
- Back-pressure with if_ready = 0 for 5 cycles after the first valid:
  - count saturates at 2 and imem_addr holds at 8.
  - Head stays at if_pc = 0.
  - After release, pc 0, 4, 8 emerge in order with no duplicates or drops.
- Redirect to 32'h0000_0041 while FULL:
  - if_valid = 0 next cycle.
  - The cycle after, if_pc = 0x40 and if_instr = ROM[16]; the buffered old words never appear.
- Wrap: redirect to 0xFC with if_ready = 1:
  - if_pc sequence 0xFC, 0x00, 0x04.
  - imem_addr upper 24 bits stay 0.
- Simultaneous pop, push and redirect while FULL: the popped head is consumed, the buffer goes EMPTY, and the next valid is the redirect target.
- Assert reset_n = 0 for 1 cycle mid-stream:
  - All outputs return to reset values on the next edge.
  - Fetch restarts at RESET_PC and fetch_count restarts at 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the ROM and queues
// fetched words in a 2-entry buffer presented to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          PC_BITS   = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t         state;
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] buf_pc    [2];
    logic [31:0]        buf_instr [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic               pop;
    logic               fetch_en;
    logic               unused_redirect_bits;

    assign if_valid  = (state != EMPTY);
    assign pop       = if_valid & if_ready;
    assign fetch_en  = ~redirect_valid & ((state != FULL) | pop);
    assign imem_addr = 32'(pc);
    assign if_instr  = if_valid ? buf_instr[rd_ptr] : NOP_INSTR;
    assign if_pc     = if_valid ? 32'(buf_pc[rd_ptr]) : 32'h0;

    // Redirect target bits outside the live PC range are dropped.
    assign unused_redirect_bits = ^{redirect_pc[31:PC_BITS], redirect_pc[1:0]};

    // PC, buffer occupancy, pointers, storage and fetch counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= EMPTY;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            pc          <= RESET_PC[PC_BITS-1:0];
            fetch_count <= 16'h0;
        end else if (redirect_valid) begin
            state  <= EMPTY;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            pc     <= {redirect_pc[PC_BITS-1:2], 2'b00};
        end else begin
            if (fetch_en) begin
                buf_pc[wr_ptr]    <= pc;
                buf_instr[wr_ptr] <= imem_rdata;
                wr_ptr            <= ~wr_ptr;
                pc                <= pc + PC_BITS'(4);
                fetch_count       <= fetch_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case (state)
                EMPTY: begin
                    if (fetch_en) state <= ONE;
                end
                ONE: begin
                    if (fetch_en && !pop) state <= FULL;
                    else if (!fetch_en && pop) state <= EMPTY;
                end
                FULL: begin
                    if (pop && !fetch_en) state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
